// File: rtl/uart_num_rx.sv
// Serial decimal-number receiver: 8N1 UART deserialiser feeding an ASCII integer parser.
// Emits one-cycle strobes for each complete number, each accepted LF, and each error.
`timescale 1ns/1ps

module uart_num_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int MAX_VAL  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  input  logic        i_en,
  output logic        o_num_valid,
  output logic [31:0] o_num_val,
  output logic        o_eol,
  output logic        o_num_err,
  output logic [1:0]  o_err_code
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [35:0]      MAX_V    = 36'(MAX_VAL);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_NUM  = 2'd1;
  localparam logic [1:0] P_BAD  = 2'd2;

  localparam logic [1:0] ERR_CHAR  = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  // ---------------------------------------------------------------------------
  // Line synchroniser
  // ---------------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_sync;
  logic [1:0] sync_fill;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_armed;
  logic             bit_done;
  logic             byte_stb;
  logic             frame_err;

  assign bit_done  = (r_cnt == BIT_END);
  assign byte_stb  = (r_state == R_STOP) && bit_done &&  rx_sync;
  assign frame_err = (r_state == R_STOP) && bit_done && !rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_armed <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          r_cnt <= '0;
          r_bit <= 3'd0;
          // The synchroniser's reset value is not a real observation of the
          // line, so arming waits until it has been flushed with live samples.
          if (sync_fill[1]) begin
            if (rx_sync) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_armed <= 1'b0;
              r_state <= R_START;
            end
          end
        end
        R_START: begin
          if (r_cnt == HALF_END) begin
            r_cnt   <= '0;
            r_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_done) begin
            r_cnt   <= '0;
            r_shift <= {rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= R_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (bit_done) begin
            r_cnt   <= '0;
            r_state <= R_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM
  // ---------------------------------------------------------------------------
  logic [1:0]  p_state;
  logic [1:0]  p_code;
  logic [31:0] acc;
  logic [35:0] nxt;
  logic        is_digit;
  logic        is_lf;
  logic        is_sep;

  assign is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);
  assign is_lf    = (r_shift == 8'h0A);
  assign is_sep   = is_lf || (r_shift == 8'h20) || (r_shift == 8'h0D);
  assign nxt      = {4'd0, acc} * 36'd10 + {32'd0, r_shift[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_IDLE;
      p_code      <= 2'd0;
      acc         <= 32'd0;
      o_num_valid <= 1'b0;
      o_num_val   <= 32'd0;
      o_eol       <= 1'b0;
      o_num_err   <= 1'b0;
      o_err_code  <= 2'd0;
    end else begin
      o_num_valid <= 1'b0;
      o_num_err   <= 1'b0;
      o_eol       <= 1'b0;
      if (frame_err) begin
        // A framing fault silently discards the token in progress.
        o_num_err  <= 1'b1;
        o_err_code <= ERR_FRAME;
        p_state    <= P_IDLE;
        acc        <= 32'd0;
      end else if (!i_en) begin
        p_state <= P_IDLE;
        acc     <= 32'd0;
      end else if (byte_stb) begin
        if (is_sep) begin
          if (p_state == P_NUM) begin
            o_num_valid <= 1'b1;
            o_num_val   <= acc;
          end else if (p_state == P_BAD) begin
            o_num_err  <= 1'b1;
            o_err_code <= p_code;
          end
          o_eol   <= is_lf;
          acc     <= 32'd0;
          p_state <= P_IDLE;
        end else if (is_digit) begin
          if (p_state != P_BAD) begin
            if (nxt > MAX_V) begin
              p_state <= P_BAD;
              p_code  <= ERR_OVF;
            end else begin
              acc     <= nxt[31:0];
              p_state <= P_NUM;
            end
          end
        end else if (p_state != P_BAD) begin
          p_state <= P_BAD;
          p_code  <= ERR_CHAR;
        end
      end
    end
  end

endmodule

// File: doc/uart_num_rx.md
# uart_num_rx

Serial number receiver for the matrix calculator's input path. It sits between the `uart_rx` pin and the input subsystem's matrix and dimension writer. It deserialises 8N1 UART bytes, parses ASCII decimal integers separated by whitespace, and hands each complete integer downstream as a one-cycle valid strobe. Malformed tokens, out-of-range values and framing faults are reported as error pulses, which the FSM and timer use to start the error countdown.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, truncated; must be ≥ 4.
- `MAX_VAL`, default 255: largest accepted value; ≤ 2^31−1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: one clock, asynchronous assertion, active-low.
- `uart_rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `i_en`  in  1  parser enable. When low, bytes are received and then dropped.
- `o_num_valid`  out  1  one-cycle strobe; `o_num_val` holds a complete integer.
- `o_num_val`  out  32  parsed value, zero-extended. Holds until the next valid.
- `o_eol`  out  1  one-cycle strobe on each accepted LF (0x0A).
- `o_num_err`  out  1  one-cycle error strobe.
- `o_err_code`  out  2  error cause, valid with `o_num_err`, held afterwards: 1 = bad character, 2 = overflow, 3 = framing.

## Operation
- **Line synchroniser.** `uart_rx` passes through 2 flip-flops; both reset to 1. The receiver uses only the synchronised bit.
- **Receiver FSM.**
  - R_IDLE: arm only after the line has been seen high. On a falling edge, go to R_START.
  - R_START: wait `CLKS_PER_BIT/2`. If the line is still low, go to R_DATA. If high, it was a glitch; go back to R_IDLE.
  - R_DATA: sample 8 bits LSB-first, one every `CLKS_PER_BIT`, then go to R_STOP.
  - R_STOP: sample after `CLKS_PER_BIT`.
    - High: issue an internal byte strobe.
    - Low: framing error, byte dropped.
    - Either way, go to R_IDLE, which waits for the line to be high again.
- **Parser FSM.** States are P_IDLE (no digits yet), P_NUM (accumulating) and P_BAD (discarding a token).
  - Digit '0'–'9' (0x30–0x39):
    - Compute `nxt = acc*10 + d` in 36 bits.
    - If `nxt > MAX_VAL`, go to P_BAD with pending code 2.
    - Otherwise `acc <= nxt` and go to P_NUM.
  - Separator (space 0x20, CR 0x0D, LF 0x0A):
    - P_NUM: emit `o_num_valid` with `o_num_val = acc`.
    - P_BAD: emit `o_num_err` with the pending code.
    - P_IDLE: no number output.
    - All cases: clear `acc` and go to P_IDLE.
    - LF additionally pulses `o_eol`, in the same cycle as any number or error output.
  - Any other byte: go to P_BAD with pending code 1, unless P_BAD already holds code 2. The first cause wins.
  - In P_BAD, digits and other bytes are ignored until a separator arrives.
- **Framing error.**
  - Immediately pulse `o_num_err` with code 3.
  - Discard any token in progress; go to P_IDLE and clear `acc`.
  - No separate error is reported for the discarded token.
- **Parser disabled.** While `i_en` is low, the parser is held in P_IDLE with `acc = 0`. Received bytes produce no outputs. Framing errors are still reported.
- **Bounds.**
  - Leading zeros are allowed: "007" gives 7.
  - A value equal to `MAX_VAL` is accepted.
  - Consecutive separators produce nothing extra.
  - A number with no trailing separator is never emitted.

## Timing
- **Reset.**
  - Both FSMs return to IDLE, `acc = 0`, all outputs 0 (`o_num_val = 0`, `o_err_code = 0`).
  - A reset during a byte aborts it. The receiver re-arms only after seeing the line high.
- **Byte strobe.** Asserted in the cycle the stop bit is sampled. This is about 9.5 bit times after the start edge, plus 2 synchroniser cycles.
- **Output latency.** Every output strobe is registered and appears exactly 1 cycle after the byte strobe that caused it. Framing-error strobes also appear 1 cycle after the stop-bit sample.
- **Simultaneous events.** If a byte strobe and `i_en` falling occur in the same cycle, the byte is dropped. The parser samples `i_en` in the byte-strobe cycle.
- **Throughput.** Back-to-back bytes are supported. The next start edge can be detected 1 cycle after R_STOP completes.
- **Output behaviour.** At most one of `o_num_valid` and `o_num_err` is high in any cycle. There is no backpressure: downstream must accept every strobe.

## Test plan
Bench uses `CLK_FREQ = 1_000_000`, `BAUD = 100_000` (10 clocks per bit), `MAX_VAL = 255`, `i_en = 1` unless stated.
- Send "12 34\n" → `o_num_valid` with 12, then with 34, the second in the same cycle as `o_eol`. Each strobe is 1 cycle after the separator's stop-bit sample.
- Send "255 256 " → valid with 255, then `o_num_err` with code 2 on the trailing space; no valid for 256.
- Send "1a2 7\r" → `o_num_err` code 1 on the space, then valid with 7.
- Send '4', then a byte with its stop bit forced low, then " " → `o_num_err` code 3 one cycle after the stop-bit sample; no valid for 4.
- Send a 3-clock low glitch with the line otherwise idle → no byte. Then send "9 " → valid with 9.
- Pull `rst_n` low halfway through the data bits of '5', release it, then send "6 " → all outputs 0 during reset; valid with 6 only.
